// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : cpu_types_pkg                                              |
// | Description : Shared CPU types: word width, RAM state, arbiter FSM state |
// |               and requester owner encoding.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // State reported by the RAM model on every cycle
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter grant state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arbstate_t;

    // Which requester most recently owned the RAM port
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arb_watchdog                                           |
// | Description : Counts granted cycles that have not yet completed; expire  |
// |               is raised combinationally once the count reaches           |
// |               TIMEOUT_CYC-1.                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Next count: clear has priority, otherwise count up while running
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clear) begin
            w_cnt_d = '0;
        end else if (run) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign expire = (r_cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Arbitrates the shared RAM port between instruction fetch   |
// |               and the load/store unit. Aborts an access on RAM ERROR or  |
// |               watchdog timeout, pulsing merr for the completing cycle.   |
// |               Define MEM_ARB_RR_EN for round-robin arbitration; default  |
// |               is fixed data-over-instruction priority.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              merr
);

    arbstate_t r_state_q;
    arbstate_t w_state_d;
    ramstate_t w_ramstate;
    logic      w_dreq;
    logic      w_access;
    logic      w_abort;
    logic      w_expire;
    logic      w_run;

    assign w_ramstate = ramstate_t'(ramstate);
    assign w_dreq     = dREN | dWEN;
    assign w_access   = (w_ramstate == ACCESS);
    // ERROR or timeout ends the access abnormally; a real ACCESS always wins
    assign w_abort    = ~w_access & ((w_ramstate == ERROR) | w_expire);

`ifdef MEM_ARB_RR_EN
    owner_t r_last_q;
    owner_t w_last_d;
    logic   w_done;

    assign w_done = ((r_state_q == GNT_I) & iREN & (w_access | w_abort)) |
                    ((r_state_q == GNT_D) & w_dreq & (w_access | w_abort));

    // Remember the owner of every completed access
    always_comb begin
        w_last_d = r_last_q;
        if (w_done) begin
            w_last_d = (r_state_q == GNT_D) ? OWN_D : OWN_I;
        end
    end

    // Last-owner register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_q <= OWN_I;
        end else begin
            r_last_q <= w_last_d;
        end
    end
`endif

    // Next state, RAM steering and per-requester handshake
    always_comb begin
        w_state_d = r_state_q;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iload     = '0;
        dload     = '0;
        iwait     = iREN;
        dwait     = w_dreq;
        merr      = 1'b0;
        w_run     = 1'b0;
        case (r_state_q)
            IDLE: begin
`ifdef MEM_ARB_RR_EN
                // Both pending: grant whichever did not own the last access
                if (w_dreq && !(iREN && (r_last_q == OWN_D))) begin
                    w_state_d = GNT_D;
                end else if (iREN) begin
                    w_state_d = GNT_I;
                end
`else
                if (w_dreq) begin
                    w_state_d = GNT_D;
                end else if (iREN) begin
                    w_state_d = GNT_I;
                end
`endif
            end
            GNT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                if (!iREN) begin
                    w_state_d = IDLE;
                end else if (w_access || w_abort) begin
                    iwait     = 1'b0;
                    merr      = w_abort;
                    w_state_d = IDLE;
                end else begin
                    w_run = 1'b1;
                end
            end
            GNT_D: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (!w_dreq) begin
                    w_state_d = IDLE;
                end else if (w_access || w_abort) begin
                    dwait     = 1'b0;
                    merr      = w_abort;
                    w_state_d = IDLE;
                end else begin
                    w_run = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Grant state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Watchdog runs only on pending granted cycles and is held clear otherwise
    mem_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (~w_run),
        .run    (w_run),
        .expire (w_expire)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                             |
// | Description : Self-checking bench for mem_arbiter: directed scenarios    |
// |               followed by randomized traffic against a transaction-level |
// |               reference model.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'd0;
    logic        merr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port, how long the access has been open
    int m_own = 0;       // 0 none, 1 fetch, 2 data
    int m_age = 0;
    bit m_last_d = 1'b0;
    int n_own, n_age;
    bit n_last;
    logic e_iwait, e_dwait;

    mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .merr(merr)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output to the model at the falling edge, prepare next model state
    task automatic check_cycle();
        logic dreq, live, acc, err, done;
        @(negedge CLK);
        dreq = dREN | dWEN;
        acc  = (ramstate == 2'd2);
        err  = (ramstate == 2'd3);
        n_own = m_own;
        n_age = m_age + 1;
        n_last = m_last_d;
        e_iwait = iREN;
        e_dwait = dreq;
        if (m_own == 0) begin
            n_age = 0;
            if (dreq && !(RR && iREN && m_last_d)) n_own = 2;
            else if (iREN) n_own = 1;
            check_eq("idle_ren", ramREN, 0);
            check_eq("idle_wen", ramWEN, 0);
            check_eq("idle_addr", ramaddr, 0);
            check_eq("idle_store", ramstore, 0);
            check_eq("idle_merr", merr, 0);
            check_eq("idle_iload", iload, 0);
            check_eq("idle_dload", dload, 0);
        end else if (m_own == 1) begin
            live = iREN;
            done = live && (acc || err || (m_age == TO - 1));
            e_iwait = iREN && !done;
            if (!live || done) n_own = 0;
            if (done) n_last = 1'b0;
            check_eq("gi_ren", ramREN, iREN);
            check_eq("gi_wen", ramWEN, 0);
            check_eq("gi_addr", ramaddr, iaddr);
            check_eq("gi_merr", merr, done && !acc);
            check_eq("gi_dload", dload, 0);
            if (done && acc) check_eq("gi_iload", iload, ramload);
        end else begin
            live = dreq;
            done = live && (acc || err || (m_age == TO - 1));
            e_dwait = dreq && !done;
            if (!live || done) n_own = 0;
            if (done) n_last = 1'b1;
            check_eq("gd_ren", ramREN, dREN && !dWEN);
            check_eq("gd_wen", ramWEN, dWEN);
            check_eq("gd_addr", ramaddr, daddr);
            check_eq("gd_store", ramstore, dstore);
            check_eq("gd_merr", merr, done && !acc);
            check_eq("gd_iload", iload, 0);
            if (done && acc) check_eq("gd_dload", dload, ramload);
        end
        check_eq("iwait", iwait, e_iwait);
        check_eq("dwait", dwait, e_dwait);
    endtask

    task automatic commit_cycle();
        @(posedge CLK);
        m_own = n_own;
        m_age = n_age;
        m_last_d = n_last;
        #1;
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            check_cycle();
            commit_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state with requests present
        iREN = 1'b1; dWEN = 1'b1;
        #3;
        check_eq("rst_iwait", iwait, 1);
        check_eq("rst_dwait", dwait, 1);
        check_eq("rst_ren", ramREN, 0);
        check_eq("rst_wen", ramWEN, 0);
        check_eq("rst_merr", merr, 0);
        iREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;

        // Fetch only: BUSY twice then ACCESS
        iREN = 1'b1; iaddr = 32'h100; ramstate = 2'd1;
        cycle(1);
        check_cycle();
        check_eq("f_ren1", ramREN, 1);
        check_eq("f_addr1", ramaddr, 32'h100);
        commit_cycle();
        cycle(1);
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        check_cycle();
        check_eq("f_iwait", iwait, 0);
        check_eq("f_iload", iload, 32'hDEADBEEF);
        commit_cycle();
        iREN = 1'b0; ramstate = 2'd1;
        cycle(1);

        // Simultaneous requests: store granted first
        iREN = 1'b1; iaddr = 32'h104; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h5A5A5A5A;
        cycle(1);
        ramstate = 2'd2;
        check_cycle();
        check_eq("s_wen", ramWEN, 1);
        check_eq("s_store", ramstore, 32'h5A5A5A5A);
        commit_cycle();
        dWEN = 1'b0;
        cycle(2);
        iREN = 1'b0;
        cycle(1);

        // ERROR on first granted cycle of a load
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd3;
        cycle(1);
        check_cycle();
        check_eq("e_merr", merr, 1);
        check_eq("e_dwait", dwait, 0);
        commit_cycle();
        dREN = 1'b0;
        check_cycle();
        check_eq("e_idle_ren", ramREN, 0);
        commit_cycle();

        // Timeout with RAM stuck BUSY
        iREN = 1'b1; iaddr = 32'h400; ramstate = 2'd1;
        cycle(1 + TO - 1);
        check_cycle();
        check_eq("t_iwait", iwait, 0);
        check_eq("t_merr", merr, 1);
        commit_cycle();
        iREN = 1'b0;
        cycle(1);

        // Flush: load dropped on second granted cycle
        dREN = 1'b1; daddr = 32'h500;
        cycle(2);
        dREN = 1'b0;
        check_cycle();
        check_eq("fl_ren", ramREN, 0);
        check_eq("fl_merr", merr, 0);
        commit_cycle();
        cycle(1);

        // Asynchronous reset in the middle of a data grant
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'h12345678;
        cycle(2);
        #2 RST = 1'b1;
        #1;
        check_eq("ar_ren", ramREN, 0);
        check_eq("ar_wen", ramWEN, 0);
        check_eq("ar_addr", ramaddr, 0);
        check_eq("ar_store", ramstore, 0);
        m_own = 0; m_age = 0; m_last_d = 1'b0;
        dWEN = 1'b0;
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        cycle(1);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            int r;
            r = int'($urandom_range(0, 19));
            ramstate = (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : (r < 17) ? 2'd3 : 2'd0;
            ramload = $urandom;
            cycle(1);
            if (iREN && !e_iwait) iREN = 1'b0;
            else if (iREN && $urandom_range(0, 19) == 0) iREN = 1'b0;
            else if (!iREN && $urandom_range(0, 2) == 0) begin
                iREN = 1'b1; iaddr = $urandom;
            end
            if ((dREN || dWEN) && !e_dwait) begin
                dREN = 1'b0; dWEN = 1'b0;
            end else if ((dREN || dWEN) && $urandom_range(0, 19) == 0) begin
                dREN = 1'b0; dWEN = 1'b0;
            end else if (!(dREN || dWEN) && $urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 2));
                dREN = (r != 1);
                dWEN = (r != 0);
                daddr = $urandom; dstore = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
